gsm_cmd_arbiter: RTL

Serializes state-change commands from several game-logic requesters into the single `flag`/`trig`/`done` command port of the game state manager. Examples of requesters are the mole-hit scorer, the miss detector, the button handler and the stage sequencer. It captures one pending command per requester, picks among pending requesters round-robin, and drives the trigger handshake. It holds `trig` until `done` is seen, then re-arms only after `done` has dropped and a low gap has elapsed. It sits between the game-logic blocks and the state manager on the 1 MHz clock domain.

---
 rtl/gsm_cmd_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/gsm_cmd_arbiter.sv
// Round-robin arbiter serialising requester commands onto the state-manager trig/done port.
// Latency: req strobe -> gsm_trig high two cycles later at the earliest; ack/err one cycle after done/timeout.
// Backpressure: one command pending per requester; a repeat request while pending sets sticky ovf and is dropped.
//
// Ports:
//   clk_1mhz, rst_n        : clock, async active-low reset
//   req[NREQ], req_flag    : per-requester command strobe and 4-bit code (requester i at [4i+3:4i])
//   ovf_clr                : clears the sticky overflow vector
//   gsm_done               : completion level/pulse from the state manager
//   gsm_flag, gsm_trig     : command code and held trigger toward the state manager
//   ack[NREQ], err, err_id : completion pulse per requester, timeout pulse and offending requester
//   ovf[NREQ], busy        : sticky overflow per requester, handshake in progress
`timescale 1ns/1ps
module gsm_cmd_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    parameter int GAP     = 2
) (
    input  logic                clk_1mhz,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_flag,
    input  logic                ovf_clr,
    input  logic                gsm_done,
    output logic [3:0]          gsm_flag,
    output logic                gsm_trig,
    output logic [NREQ-1:0]     ack,
    output logic                err,
    output logic [2:0]          err_id,
    output logic [NREQ-1:0]     ovf,
    output logic                busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
    localparam logic [7:0]    TO_W   = 8'(TIMEOUT);
    localparam logic [3:0]    GAP_W  = 4'(GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE,
        S_GAP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [NREQ-1:0]         r_pend;
    logic [NREQ-1:0][3:0]    r_flag;
    logic [NREQ-1:0]         r_ovf;
    logic [IW-1:0]           r_ptr;
    logic [IW-1:0]           r_gnt;
    logic [7:0]              r_wait;
    logic [3:0]              r_gap;
    logic [3:0]              r_gsm_flag;
    logic                    r_trig;
    logic [NREQ-1:0]         r_ack;
    logic                    r_err;
    logic [2:0]              r_err_id;

    logic                    w_gnt_vld;
    logic [IW-1:0]           w_gnt_idx;
    logic [IW:0]             w_sum;
    logic                    w_grant;
    logic                    w_done_evt;
    logic                    w_timeout;
    logic                    w_trig_nxt;
    logic [NREQ-1:0]         w_ack_nxt;
    logic                    w_err_nxt;
    logic [7:0]              w_wait_nxt;
    logic [3:0]              w_gap_nxt;
    logic [NREQ-1:0]         w_clr;
    logic [NREQ-1:0]         w_ovf_set;

    // First pending index after the pointer, wrapping. Scanning from the
    // farthest offset down lets the nearest pending requester win.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            if (r_pend[w_sum[IW-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_trig_nxt  = r_trig;
        w_ack_nxt   = '0;
        w_err_nxt   = 1'b0;
        w_grant     = 1'b0;
        w_done_evt  = 1'b0;
        w_timeout   = 1'b0;
        w_wait_nxt  = r_wait;
        w_gap_nxt   = r_gap;
        case (r_state)
            S_IDLE: begin
                // A done still high from the previous handshake must not
                // complete a fresh command, so grants wait for it to drop.
                if (w_gnt_vld && !gsm_done) begin
                    w_grant     = 1'b1;
                    w_trig_nxt  = 1'b1;
                    w_wait_nxt  = '0;
                    w_state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (gsm_done) begin
                    w_done_evt  = 1'b1;
                    w_trig_nxt  = 1'b0;
                    w_ack_nxt   = NREQ'(1) << r_gnt;
                    w_state_nxt = S_RELEASE;
                end else if (r_wait == TO_W) begin
                    w_done_evt  = 1'b1;
                    w_timeout   = 1'b1;
                    w_trig_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_wait_nxt  = r_wait + 8'd1;
                end
            end
            S_RELEASE: begin
                if (!gsm_done) begin
                    w_gap_nxt   = GAP_W;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap <= 4'd1) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt   = r_gap - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_trig_nxt  = 1'b0;
            end
        endcase
    end

    // Pending bit of the granted requester clears on ack or timeout; a new
    // strobe in that same cycle refills the slot instead of overflowing.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_clr[i] = w_done_evt && (r_gnt == IW'(i));
        end
        w_ovf_set = req & r_pend & ~w_clr;
    end

    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            r_flag     <= '0;
            r_ovf      <= '0;
            r_ptr      <= IW'(NREQ-1);
            r_gnt      <= '0;
            r_wait     <= '0;
            r_gap      <= '0;
            r_gsm_flag <= '0;
            r_trig     <= 1'b0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_err_id   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_trig  <= w_trig_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_wait  <= w_wait_nxt;
            r_gap   <= w_gap_nxt;
            if (w_grant) begin
                r_gnt      <= w_gnt_idx;
                r_ptr      <= w_gnt_idx;
                r_gsm_flag <= r_flag[w_gnt_idx];
            end
            if (w_timeout) begin
                r_err_id <= 3'(r_gnt);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (!r_pend[i] || w_clr[i])) begin
                    r_pend[i] <= 1'b1;
                    r_flag[i] <= req_flag[4*i +: 4];
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            // A fresh overflow wins over a simultaneous clear.
            r_ovf <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
        end
    end

    assign gsm_flag = r_gsm_flag;
    assign gsm_trig = r_trig;
    assign ack      = r_ack;
    assign err      = r_err;
    assign err_id   = r_err_id;
    assign ovf      = r_ovf;
    assign busy     = (r_state != S_IDLE);

endmodule
